// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-seg driver: edge-detected scan, double-buffered data.
// Ports: clk, clr_n, scan_in, load, data_in, dp_in -> a_to_g, dp, an, frame.
// Optional SEG7_LZ_BLANK_EN macro enables leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  scan_in,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            a_to_g,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic                s0;
  logic                s1;
  logic                rise;
  logic                wrap;
  logic                wrap_q;
  logic                pending;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   disp_dp;
  logic [DIGITS-1:0]   shadow_dp;
  logic [3:0]          nib;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an_nx;
  logic                blank;

  assign rise = s0 & ~s1;
  assign wrap = rise & (idx == LAST);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= scan_in;
      s1 <= s0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      idx <= '0;
    end else if (rise) begin
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // A load that coincides with the wrap bypasses the shadow so the
  // newest value is the one shown.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      disp      <= '0;
      disp_dp   <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
    end else if (load && wrap) begin
      disp    <= data_in;
      disp_dp <= dp_in;
      pending <= 1'b0;
    end else if (load) begin
      shadow    <= data_in;
      shadow_dp <= dp_in;
      pending   <= 1'b1;
    end else if (wrap && pending) begin
      disp    <= shadow;
      disp_dp <= shadow_dp;
      pending <= 1'b0;
    end
  end

  assign nib = disp[{idx, 2'b00} +: 4];

  always_comb begin
    seg = 7'b1111111;
    unique case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
    endcase
  end

  always_comb begin
    an_nx      = '1;
    an_nx[idx] = 1'b0;
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] lead;
  logic              run;

  // lead[i]: digit i and every digit above it are zero with dp off.
  // Digit 0 is never part of the leading run.
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run     = run & (disp[4*i +: 4] == 4'h0) & ~disp_dp[i];
      lead[i] = run;
    end
  end

  assign blank = lead[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an     <= '1;
      a_to_g <= 7'b1111111;
      dp     <= 1'b1;
      wrap_q <= 1'b0;
      frame  <= 1'b0;
    end else begin
      an     <= an_nx;
      a_to_g <= blank ? 7'b1111111 : seg;
      dp     <= blank | ~disp_dp[idx];
      // Two stages so frame lines up with digit 0's anode.
      wrap_q <= wrap;
      frame  <= wrap_q;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed seven-segment display driver for the board's common-anode digit bank. It sits directly downstream of the clock divider: it takes one divided-counter bit as its scan-rate input, detects its rising edge in the system clock domain, and steps an active digit through the display. Display data is double-buffered so that a new value never tears mid-frame. The PRAM/SRAM test logic uses it to show addresses, data and error counts.

## Interface
- DIGITS, 4 — number of digits; legal range 2–8.
- clk  in  1  system clock; the same clock that feeds the divider.
- clr_n  in  1  asynchronous, active-low reset.
- scan_in  in  1  divided-clock bit (e.g. the divider's bit 17); a level, synchronous to clk; edge-detected internally.
- load  in  1  one-cycle strobe that captures data_in and dp_in.
- data_in  in  4*DIGITS  hex nibbles; nibble i maps to digit i, and digit 0 is the rightmost.
- dp_in  in  DIGITS  decimal point per digit; 1 = lit.
- a_to_g  out  7  segments, active-low; [6]=a … [0]=g.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit anodes, active-low, exactly one low when not in reset.
- frame  out  1  one-cycle pulse when the index wraps from DIGITS-1 to 0.

## Operation
- **Edge detect.**
  - Two-flop history: s0 <= scan_in, s1 <= s0.
  - rise = s0 & ~s1.
  - Only rising edges advance the scan; level and falling edges are ignored.
- **Digit index.**
  - idx has width ceil(log2 DIGITS).
  - On rise, idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - Index values at or above DIGITS are never reached.
- **Double buffering.**
  - load writes shadow_data/shadow_dp and sets pending.
  - At wrap (rise with idx == DIGITS-1): if pending, then disp <= shadow and pending is cleared.
  - load in the same cycle as wrap: disp <= data_in/dp_in directly, and pending stays 0. New data wins.
  - A second load before wrap overwrites shadow; only the latest value is shown.
- **Decode.**
  - Hex 0–F, standard patterns, active-low.
  - Examples: 0 = 0000001, 1 = 1001111, 8 = 0000000, A = 0001000, F = 0111000.
- **Outputs.** All registered:
  - an, a_to_g and dp are computed from the current idx and disp every cycle.
  - frame is registered from wrap.

## Timing
- **Reset values.**
  - an = all 1, a_to_g = 1111111, dp = 1, frame = 0.
  - idx = 0, disp = shadow = 0, pending = 0, s0 = s1 = 0.
- **First clk after clr_n deasserts.** Outputs show digit 0 of disp: an[0] = 0, a_to_g = 0000001.
- **Latency.**
  - scan_in rising to idx change: 2 clk.
  - idx change to an/a_to_g update: 1 clk, so 3 clk total.
- **Timing of load.**
  - load to visible: at the next wrap plus 1 clk.
  - load coincident with wrap: visible 1 clk later.
- **frame.** Asserted exactly 1 clk, in the same cycle that the anode pattern for digit 0 first appears.
- **Reset mid-scan.** Immediately blanks all outputs and discards shadow and pending.
- **Minimum scan_in period.** 4 clk. Faster toggling still steps once per detected rise, with no skipped or duplicated index.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking.
  - Starting from digit DIGITS-1 downward, each digit whose disp nibble is 0 and whose dp bit is 0 is shown blank: a_to_g = 1111111, dp = 1, anode still driven low.
  - Blanking stops at the first non-zero nibble or set dp bit.
  - Digit 0 is never blanked, so 0x0000 shows a single "0".
- Macro undefined: every digit is always decoded, including leading zeros.

## Test plan
- **Reset.**
  - Stimulus: hold clr_n = 0 for 5 clk with scan_in toggling.
  - Response: an = 1111, a_to_g = 1111111, dp = 1, frame = 0.
  - Stimulus: release clr_n.
  - Response: the next clk gives an = 1110, a_to_g = 0000001.
- **Scan order.**
  - Stimulus: load 0x1A8F; drive scan_in as a square wave with an 8-clk period.
  - Response: an cycles 1110 → 1101 → 1011 → 0111 → 1110, each appearing 3 clk after its scan_in rise.
  - Response: from the first frame pulse onward, segments are F, 8, A, 1 = 0111000, 0000000, 0001000, 1001111.
- **Tear-free update.**
  - Stimulus: load 0x1234 while idx = 1; then load 0x5678 at idx = 2.
  - Response: the old value is held until wrap; then 0x5678 is shown; 0x1234 is never displayed.
- **Load at wrap.**
  - Stimulus: load 0x00FF in the same cycle as the idx 3 → 0 rise.
  - Response: digit 0 shows F one clk later; pending = 0.
- **Leading-zero blanking.**
  - With SEG7_LZ_BLANK_EN: load 0x0005 → digits 3..1 blank, digit 0 = 0100100.
  - With SEG7_LZ_BLANK_EN: load 0x0000 with dp_in = 0100 → digits 3 blank, digit 2 shows "0" with dp = 0, digits 1..0 show "0".
  - Without the macro: all digits decoded.
- **Reset mid-frame.**
  - Stimulus: assert clr_n low at idx = 2 with pending = 1.
  - Response: outputs blank asynchronously.
  - Stimulus: release clr_n.
  - Response: disp = 0 is shown starting at digit 0.
